// File: rtl/alu_arbiter_if.sv
// Opcode package and request/response bundle shared by alu_arbiter and its clients.
// Defining ALU_ARBITER_LOCK_EN adds the per-requester req_lock_i signal.
`timescale 1ns/1ps
package alu_arbiter_pkg;
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_AND = 3'd1,
      ALU_OR  = 3'd2,
      ALU_XOR = 3'd3,
      ALU_NOT = 3'd4,
      ALU_NEG = 3'd5,
      ALU_LSL = 3'd6,
      ALU_ASR = 3'd7
   } alu_operation_e;
endpackage

interface alu_arbiter_if #(
   parameter int Width  = 4,
   parameter int NumReq = 3
);
   import alu_arbiter_pkg::*;
   localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

   logic [NumReq-1:0]       req_valid_i;
   logic [NumReq-1:0]       req_ready_o;
   logic [NumReq*Width-1:0] req_a_i;
   logic [NumReq*Width-1:0] req_b_i;
   alu_operation_e          req_op_i [NumReq];
`ifdef ALU_ARBITER_LOCK_EN
   logic [NumReq-1:0]       req_lock_i;
`endif
   logic                    rsp_valid_o;
   logic                    rsp_ready_i;
   logic [IdW-1:0]          rsp_id_o;
   logic [Width-1:0]        rsp_result_o;

   modport master (
      output req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
`ifdef ALU_ARBITER_LOCK_EN
      output req_lock_i,
`endif
      input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
   );

   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
`ifdef ALU_ARBITER_LOCK_EN
      input  req_lock_i,
`endif
      output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NumReq requesters,
// with a one-entry registered response stage. ALU_ARBITER_LOCK_EN enables priority lock.
`timescale 1ns/1ps
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int Width = 4
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  alu_operation_e   op_i,
   output logic [Width-1:0] result_o
);
   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_NOT: result_o = ~a_i;
         ALU_NEG: result_o = -a_i;
         ALU_LSL: result_o = a_i << b_i;
         ALU_ASR: result_o = $signed(a_i) >>> b_i;
         default: result_o = '0;
      endcase
   end
endmodule

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int Width  = 4,
   parameter int NumReq = 3
) (
   input logic          clk_i,
   input logic          rst_ni,
   alu_arbiter_if.slave bus
);
   localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic {EMPTY, FULL} state_e;

   state_e           state_q, state_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IdW-1:0]   rsp_id_q, rsp_id_d;
   logic [Width-1:0] rsp_result_q, rsp_result_d;
   logic [IdW-1:0]   ptr_q, ptr_d;

   logic             can_accept;
   logic             found_valid;
   logic [IdW-1:0]   found_id;
   logic             grant_valid;
   logic [IdW-1:0]   sel_id;
   logic [IdW-1:0]   next_ptr;
   logic [NumReq-1:0] req_ready;
   logic [Width-1:0] alu_result;

   logic [Width-1:0] a_arr [NumReq];
   logic [Width-1:0] b_arr [NumReq];

   generate
      for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
         assign a_arr[gi] = bus.req_a_i[gi*Width +: Width];
         assign b_arr[gi] = bus.req_b_i[gi*Width +: Width];
      end
   endgenerate

   // Rotating scan: the first valid requester at or after ptr wins.
   always_comb begin
      int idx;
      idx         = 0;
      found_valid = 1'b0;
      found_id    = ptr_q;
      for (int k = 0; k < NumReq; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NumReq) idx = idx - NumReq;
         if (!found_valid && bus.req_valid_i[IdW'(idx)]) begin
            found_valid = 1'b1;
            found_id    = IdW'(idx);
         end
      end
   end

   always_comb begin
      can_accept  = (state_q == EMPTY) || (rsp_valid_q && bus.rsp_ready_i);
      grant_valid = found_valid && can_accept && rst_ni;
      sel_id      = grant_valid ? found_id : ptr_q;
      next_ptr    = (sel_id == IdW'(NumReq - 1)) ? '0 : sel_id + IdW'(1);
      req_ready   = '0;
      if (grant_valid) req_ready[sel_id] = 1'b1;
   end

   alu #(.Width(Width)) u_alu (
      .a_i      (a_arr[sel_id]),
      .b_i      (b_arr[sel_id]),
      .op_i     (bus.req_op_i[sel_id]),
      .result_o (alu_result)
   );

   always_comb begin
      state_d      = state_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      ptr_d        = ptr_q;
      if (grant_valid) begin
         state_d      = FULL;
         rsp_valid_d  = 1'b1;
         rsp_id_d     = sel_id;
         rsp_result_d = alu_result;
`ifdef ALU_ARBITER_LOCK_EN
         // A locked winner keeps top priority for its next operation.
         ptr_d        = bus.req_lock_i[sel_id] ? sel_id : next_ptr;
`else
         ptr_d        = next_ptr;
`endif
      end else if (rsp_valid_q && bus.rsp_ready_i) begin
         state_d     = EMPTY;
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= EMPTY;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         ptr_q        <= '0;
      end else begin
         state_q      <= state_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         ptr_q        <= ptr_d;
      end
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.rsp_valid_o  = rsp_valid_q;
   assign bus.rsp_id_o     = rsp_id_q;
   assign bus.rsp_result_o = rsp_result_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then randomized traffic,
// checked against a behavioural model of arbitration and ALU arithmetic.
`timescale 1ns/1ps
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;
   localparam int W = 4;
   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.Width(W), .NumReq(N)) bus();

   alu_arbiter #(.Width(W), .NumReq(N)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   typedef struct {
      int id;
      int result;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   m_ptr = 0;
   bit   m_full = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic int ref_alu(alu_operation_e op, int a, int b);
      int sa;
      sa = (a >= 8) ? a - 16 : a;
      case (op)
         ALU_ADD: return (a + b) % 16;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_NOT: return 15 - a;
         ALU_NEG: return (16 - a) % 16;
         ALU_LSL: return (a << b) & 15;
         ALU_ASR: return (sa >>> b) & 15;
         default: return 0;
      endcase
   endfunction

   task automatic set_req(int i, bit v, logic [3:0] a, logic [3:0] b, alu_operation_e op);
      bus.req_valid_i[i]       = v;
      bus.req_a_i[i*W +: W]    = a;
      bus.req_b_i[i*W +: W]    = b;
      bus.req_op_i[i]          = op;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd0, 4'd0, ALU_ADD);
`ifdef ALU_ARBITER_LOCK_EN
      bus.req_lock_i = '0;
`endif
   endtask

   // Reference model: evaluated mid-cycle on the inputs the DUT sees before the next edge.
   task automatic model_eval();
      int g;
      int best;
      bit can_acc;
      logic [N-1:0] exp_ready;
      exp_t e;
      if (!rst_n) begin
         chk("ready_in_reset", 32'(bus.req_ready_o), 32'd0);
         exp_q.delete();
         m_ptr  = 0;
         m_full = 1'b0;
         return;
      end
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_full));
      can_acc = !m_full || bus.rsp_ready_i;
      g = -1;
      best = N;
      if (can_acc) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid_i[i]) begin
               int d;
               d = (i - m_ptr + N) % N;
               if (d < best) begin
                  best = d;
                  g = i;
               end
            end
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
      if (g >= 0) begin
         e.id     = g;
         e.result = ref_alu(bus.req_op_i[g], int'(bus.req_a_i[g*W +: W]), int'(bus.req_b_i[g*W +: W]));
         exp_q.push_back(e);
         m_full = 1'b1;
         m_ptr  = (g + 1) % N;
`ifdef ALU_ARBITER_LOCK_EN
         if (bus.req_lock_i[g]) m_ptr = g;
`endif
      end else if (m_full && bus.rsp_ready_i) begin
         m_full = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
      model_eval();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the oldest expected response on every response handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: got id %0d result %0h expected no response",
                        bus.rsp_id_o, bus.rsp_result_o);
            end else begin
               e = exp_q.pop_front();
               $display("[TB] rsp id=%0d result=%0h", bus.rsp_id_o, bus.rsp_result_o);
               chk("rsp_id", 32'(bus.rsp_id_o), 32'(e.id));
               chk("rsp_result", 32'(bus.rsp_result_o), 32'(e.result));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_all();
      bus.rsp_ready_i = 1'b1;
      rst_n = 1'b0;
      #1;
      step();
      step();
      chk("reset_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("reset_id", 32'(bus.rsp_id_o), 32'd0);
      chk("reset_result", 32'(bus.rsp_result_o), 32'd0);
      rst_n = 1'b1;
      step();

      // Single request
      set_req(0, 1'b1, 4'b0000, 4'b0001, ALU_ADD);
      step();
      clear_all();
      chk("single_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("single_id", 32'(bus.rsp_id_o), 32'd0);
      chk("single_result", 32'(bus.rsp_result_o), 32'b0001);
      step();
      step();

      // Three-way contention held valid: ptr is 1 here, so wind back to 0 first
      set_req(2, 1'b1, 4'd1, 4'd1, ALU_ADD);
      step();
      clear_all();
      set_req(0, 1'b1, 4'b0010, 4'b0001, ALU_OR);
      set_req(1, 1'b1, 4'b0010, 4'b0001, ALU_AND);
      set_req(2, 1'b1, 4'b0010, 4'b0011, ALU_XOR);
      repeat (3) step();
      clear_all();
      step();

      // Backpressure
      set_req(0, 1'b1, 4'd3, 4'd4, ALU_ADD);
      step();
      clear_all();
      bus.rsp_ready_i = 1'b0;
      set_req(1, 1'b1, 4'd7, 4'd9, ALU_XOR);
      repeat (4) begin
         step();
         chk("bp_result", 32'(bus.rsp_result_o), 32'd7);
      end
      bus.rsp_ready_i = 1'b1;
      step();
      clear_all();
      chk("bp_new_result", 32'(bus.rsp_result_o), 32'(4'd7 ^ 4'd9));
      step();

      // Wrap-around: ptr is 2, grant req2 so it wraps to 0
      set_req(2, 1'b1, 4'd5, 4'd5, ALU_ADD);
      step();
      clear_all();
      set_req(0, 1'b1, 4'b1010, 4'b0001, ALU_ASR);
      set_req(2, 1'b1, 4'b1010, 4'b0001, ALU_LSL);
      step();
      set_req(0, 1'b0, 4'd0, 4'd0, ALU_ADD);
      chk("wrap_first", 32'(bus.rsp_result_o), 32'b1101);
      step();
      clear_all();
      chk("wrap_second", 32'(bus.rsp_result_o), 32'b0100);
      step();

      // Reset mid-operation
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'(i + 2), 4'd3, ALU_ADD);
      step();
      rst_n = 1'b0;
      step();
      chk("midrst_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("midrst_result", 32'(bus.rsp_result_o), 32'd0);
      rst_n = 1'b1;
      step();
      chk("midrst_first_id", 32'(bus.rsp_id_o), 32'd0);
      clear_all();
      step();

`ifdef ALU_ARBITER_LOCK_EN
      // ptr is 1 after the post-reset grant to req0
      set_req(0, 1'b1, 4'd1, 4'd1, ALU_ADD);
      set_req(2, 1'b1, 4'd2, 4'd2, ALU_ADD);
      set_req(1, 1'b1, 4'b0011, 4'd0, ALU_NOT);
      bus.req_lock_i[1] = 1'b1;
      step();
      set_req(1, 1'b1, 4'b0011, 4'd0, ALU_NEG);
      step();
      bus.req_lock_i[1] = 1'b0;
      step();
      chk("lock_third_id", 32'(bus.rsp_id_o), 32'd1);
      set_req(1, 1'b0, 4'd0, 4'd0, ALU_ADD);
      step();
      chk("lock_release_id", 32'(bus.rsp_id_o), 32'd2);
      clear_all();
      step();
`endif

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         for (int i = 0; i < N; i++)
            set_req(i, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                    alu_operation_e'(3'($urandom_range(0, 7))));
`ifdef ALU_ARBITER_LOCK_EN
         bus.req_lock_i = 3'($urandom);
`endif
         bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
         step();
      end

      rst_n = 1'b1;
      clear_all();
      bus.rsp_ready_i = 1'b1;
      repeat (3) step();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between NumReq requesters.
- Round-robin arbitration selects one requester per cycle. Its operands and opcode drive the ALU, and the result is captured into a one-entry registered response stage.
- Valid/ready handshakes on both sides. Sits between the execution-stage requesters (e.g. integer pipe, address generator) and the shared ALU.

Parameters:
- Width, 4, operand/result width; passed through to the `alu` instance.
- NumReq, 3, number of requesters; legal range 2..8.
- IdW, $clog2(NumReq), width of the requester id (localparam).

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- req_valid_i  input  NumReq  per-requester request valid
- req_ready_o  output  NumReq  per-requester accept (one-hot or zero)
- req_a_i  input  NumReq*Width  operand A, requester i at [i*Width +: Width]
- req_b_i  input  NumReq*Width  operand B, same packing
- req_op_i  input  NumReq x alu_operation_e  opcode per requester
- rsp_valid_o  output  1  response register holds a result
- rsp_ready_i  input  1  consumer accepts response
- rsp_id_o  output  IdW  index of requester that produced the result
- rsp_result_o  output  Width  registered ALU result

Behaviour:
- Reset (rst_ni=0 sampled on clk_i edge): rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, round-robin pointer ptr=0, FSM=EMPTY.
- req_ready_o is combinational and low throughout any cycle in which rst_ni=0.
- FSM has two states:
  - EMPTY: response register invalid.
  - FULL: response register valid.
- can_accept = (state==EMPTY) | (rsp_valid_o & rsp_ready_i). Full throughput when the consumer is always ready.
- Grant, combinational:
  - When can_accept, grant the first i with req_valid_i[i]=1, scanning ptr, ptr+1, …, NumReq-1, 0, …, ptr-1.
  - req_ready_o[grant]=1 and all other bits 0.
  - No valid request, or !can_accept -> req_ready_o=0.
- Datapath: ALU inputs are muxed from the granted requester. When there is no grant, the mux selects requester ptr; the result is discarded.
- On a grant (handshake req_valid_i[g] & req_ready_o[g]) at edge N:
  - rsp_result_o <= alu result, rsp_id_o <= g, rsp_valid_o <= 1, state -> FULL.
  - ptr <= (g==NumReq-1) ? 0 : g+1, i.e. wrap-around.
  - Latency is exactly 1 cycle: the result is visible after edge N.
- Response drain without a new grant (rsp_valid_o & rsp_ready_i & no grant): rsp_valid_o <= 0, state -> EMPTY. rsp_id_o and rsp_result_o hold their last values.
- Simultaneous drain and grant: the new result replaces the old in the same edge and rsp_valid_o stays 1.
- Backpressure: while FULL and rsp_ready_i=0, rsp_valid_o, rsp_id_o and rsp_result_o are held stable and ptr is unchanged.
- Requesters may drop req_valid_i without a handshake; no state is affected.
- ALU arithmetic follows `alu` semantics, modulo 2^Width, no carry/overflow outputs.
- Reset mid-operation: pending response discarded, ptr=0, no handshake completes in the reset cycle.

Optional Feature:
- Macro: ALU_ARBITER_LOCK_EN.
- Defined:
  - Adds input port req_lock_i [NumReq].
  - If the granted requester g has req_lock_i[g]=1 at the handshake, ptr <= g instead of g+1. g keeps top priority for back-to-back operations (e.g. multi-word add sequences) while it stays valid.
  - The lock releases when g completes a handshake with req_lock_i[g]=0.
- Undefined: no req_lock_i port; pointer always advances as described above.

Test Plan (Width=4, NumReq=3, rsp_ready_i=1 unless stated):
- Single request: after reset, req0 a=0000 b=0001 ADD -> req_ready_o=001 that cycle; next cycle rsp_valid_o=1, rsp_id_o=0, rsp_result_o=0001.
- Three-way contention, held valid across cycles:
  - req0 OR 0010/0001, req1 AND 0010/0001, req2 XOR 0010/0011.
  - Expected: grants 0,1,2 on consecutive cycles; responses (id,result) = (0,0011),(1,0000),(2,0001); rsp_valid_o continuous for 3 cycles.
- Backpressure:
  - Hold rsp_ready_i=0 with rsp_valid_o=1 and req1 valid -> req_ready_o=000; rsp outputs stable for 4 cycles.
  - Raise rsp_ready_i -> req1 granted in that same cycle, next result replaces old with no bubble.
- Wrap-around: after a grant to req2, assert req0 and req2 with ASR 1010/0001 and LSL 1010/0001 -> req0 granted first (result 1101), then req2 (result 0100).
- Reset mid-operation:
  - Drive rst_ni=0 for one edge while rsp_valid_o=1 and all requesters valid -> after edge rsp_valid_o=0, rsp_result_o=0000, req_ready_o=000 during the reset cycle.
  - After release, req0 is granted first.
- (ALU_ARBITER_LOCK_EN) req1 locked with NOT/NEG ops, req0 and req2 valid -> req1 granted on 3 consecutive cycles. Drop lock on the 3rd -> next grant goes to req2.
